// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants, state encoding and helpers for the radix-2 divider
package div_unit_pkg;

    localparam int RegisterBus = 32;

    localparam logic [RegisterBus-1:0] ZeroWord = '0;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    function automatic logic [RegisterBus-1:0] negate(input logic [RegisterBus-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result handshake between execute and the divider
interface div_unit_if;
    import div_unit_pkg::*;

    logic                     signed_div_i;
    logic [RegisterBus-1:0]   opdata1_i;
    logic [RegisterBus-1:0]   opdata2_i;
    logic                     start_i;
    logic                     annul_i;
    logic [2*RegisterBus-1:0] result_o;
    logic                     ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle restoring divider for DIV/DIVU, result = {remainder, quotient}
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_t               state, state_n;
    logic [64:0]              dividend, dividend_n;
    logic [RegisterBus-1:0]   divisor, divisor_n;
    logic [5:0]               cnt, cnt_n;
    logic                     neg1, neg1_n;
    logic                     neg2, neg2_n;
    logic                     sdiv, sdiv_n;
    logic [2*RegisterBus-1:0] result, result_n;
    logic                     ready, ready_n;

    logic [32:0]              diff;
    logic [RegisterBus-1:0]   quot, rem;
    logic [RegisterBus-1:0]   mag1, mag2;

    assign bus.result_o = result;
    assign bus.ready_o  = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            dividend <= '0;
            divisor  <= '0;
            cnt      <= '0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            sdiv     <= 1'b0;
            result   <= '0;
            ready    <= DivResultNotReady;
        end else begin
            state    <= state_n;
            dividend <= dividend_n;
            divisor  <= divisor_n;
            cnt      <= cnt_n;
            neg1     <= neg1_n;
            neg2     <= neg2_n;
            sdiv     <= sdiv_n;
            result   <= result_n;
            ready    <= ready_n;
        end
    end

    always_comb begin
        state_n    = state;
        dividend_n = dividend;
        divisor_n  = divisor;
        cnt_n      = cnt;
        neg1_n     = neg1;
        neg2_n     = neg2;
        sdiv_n     = sdiv;
        result_n   = result;
        ready_n    = ready;

        diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
        // Most-negative operand maps to itself, which is still the correct unsigned magnitude.
        mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? negate(bus.opdata1_i) : bus.opdata1_i;
        mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? negate(bus.opdata2_i) : bus.opdata2_i;
        quot = (sdiv && (neg1 ^ neg2)) ? negate(dividend[31:0]) : dividend[31:0];
        rem  = (sdiv && neg1) ? negate(dividend[64:33]) : dividend[64:33];

        unique case (state)
            DivFree: begin
                ready_n  = DivResultNotReady;
                result_n = '0;
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (bus.opdata2_i == ZeroWord) begin
                        state_n = DivByZero;
                    end else begin
                        dividend_n = {ZeroWord, mag1, 1'b0};
                        divisor_n  = mag2;
                        neg1_n     = bus.signed_div_i & bus.opdata1_i[31];
                        neg2_n     = bus.signed_div_i & bus.opdata2_i[31];
                        sdiv_n     = bus.signed_div_i;
                        cnt_n      = '0;
                        state_n    = DivOn;
                    end
                end
            end
            DivByZero: begin
                result_n = '0;
                ready_n  = DivResultReady;
                state_n  = DivEnd;
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_n = DivFree;
                end else if (!cnt[5]) begin
                    if (diff[32]) begin
                        dividend_n = {dividend[63:0], 1'b0};
                    end else begin
                        dividend_n = {diff[31:0], dividend[31:0], 1'b1};
                    end
                    cnt_n = cnt + 6'd1;
                end else begin
                    result_n = {rem, quot};
                    ready_n  = DivResultReady;
                    cnt_n    = '0;
                    state_n  = DivEnd;
                end
            end
            DivEnd: begin
                if (bus.start_i == DivStop) begin
                    state_n  = DivFree;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                end
            end
            default: state_n = DivFree;
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit: vector table, corner sequences, random vs model
module tb_div_unit;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (!sg) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction

    // Called at a negedge; raises start and counts posedges until ready, leaving start held.
    task automatic start_and_wait(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                  input bit scramble, output int lat, output logic [63:0] res);
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        lat = -1;
        res = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (scramble && n == 1) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sg;
            end
            if (bus.ready_o) begin
                lat = n;
                res = bus.result_o;
                break;
            end
        end
    endtask

    task automatic drop_start(input string name);
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({name, " ready after drop"}, {63'd0, bus.ready_o}, 64'd0);
        chk({name, " result after drop"}, bus.result_o, 64'd0);
    endtask

    task automatic run_op(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                          input bit scramble);
        int          lat;
        logic [63:0] res;
        start_and_wait(sg, a, b, scramble, lat, res);
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, res, exp);
        drop_start(name);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        bit          ready_seen;
        logic        sg;
        logic [31:0] a, b;

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset ready", {63'd0, bus.ready_o}, 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 34});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},  34});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD},  34});
        vecs.push_back('{1'b0, 32'd5,          32'd0,          64'd0,                           2});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},          34});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF},          34});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'd3},          34});
        vecs.push_back('{1'b0, 32'd3,          32'd10,         {32'd3, 32'd0},                  34});
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

        // Annul mid-iteration, then an immediate new request.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'hFFFF_FFFF;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        ready_seen = 1'b0;
        for (int n = 0; n < 11; n++) begin
            @(negedge clk);
            ready_seen |= bus.ready_o;
        end
        bus.annul_i = 1'b1;
        @(negedge clk);
        ready_seen |= bus.ready_o;
        chk("annul ready never", {63'd0, ready_seen}, 64'd0);
        run_op("after annul", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 34, 1'b0);

        // Reset while iterating.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst in ON ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst in ON result", bus.result_o, 64'd0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        run_op("after rst ON", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 34, 1'b0);

        // Reset while holding a finished result.
        start_and_wait(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, lat, res);
        chk("pre rst END result", res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        repeat (3) @(negedge clk);
        chk("END hold result", bus.result_o, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        rst = 1'b1;
        @(negedge clk);
        chk("rst in END ready", {63'd0, bus.ready_o}, 64'd0);
        chk("rst in END result", bus.result_o, 64'd0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        run_op("after rst END", 1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 34, 1'b0);

        // Operands wiggled after the start edge must not matter.
        run_op("scramble", 1'b1, 32'hFFFF_FC18, 32'd33, ref_div(1'b1, 32'hFFFF_FC18, 32'd33), 34, 1'b1);

        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 20));
                1:       b = -32'($urandom_range(1, 20));
                2:       b = (i % 6 == 0) ? 32'd0 : $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rand%0d", i), sg, a, b, ref_div(sg, a, b), (b == 32'd0) ? 2 : 34, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
